// File: rtl/i2c_reg_xfer_seq.sv
// APB master sequencer: expands single-byte I2C register read/write requests into the
// START/address/data/STOP command and STATUS polling sequence of an APB I2C master.
module i2c_reg_xfer_seq #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter logic [15:0] PRESCALE       = 16'd49
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [6:0]                req_dev_i,
    input  logic [7:0]                req_reg_i,
    input  logic [7:0]                req_wdata_i,
    output logic                      rsp_valid_o,
    output logic [7:0]                rsp_rdata_o,
    output logic [1:0]                rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
    output logic [31:0]               PWDATA_o,
    output logic                      PWRITE_o,
    output logic                      PSEL_o,
    output logic                      PENABLE_o,
    input  logic [31:0]               PRDATA_i,
    input  logic                      PREADY_i
);
    localparam logic [APB_ADDR_WIDTH-1:0] A_PRE    = APB_ADDR_WIDTH'(8'h00);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL   = APB_ADDR_WIDTH'(8'h04);
    localparam logic [APB_ADDR_WIDTH-1:0] A_TX     = APB_ADDR_WIDTH'(8'h08);
    localparam logic [APB_ADDR_WIDTH-1:0] A_RX     = APB_ADDR_WIDTH'(8'h0C);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CMD    = APB_ADDR_WIDTH'(8'h10);
    localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'(8'h14);

    typedef enum logic [3:0] {
        RST_PRE, RST_CTRL, IDLE, WR_TX, WR_CMD, POLL, RD_RX, STOP_CMD, STOP_POLL, RESP
    } state_t;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [31:0]               wdata;
        logic                      write;
    } apb_t;

    state_t     state;
    logic [1:0] step;
    logic       req_wr;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_dat;
    apb_t       apb;
    logic       psel, penable, req_ready, rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;

    logic st_rxack, st_busy, st_al, st_tip, unused_prdata;
    assign st_rxack      = PRDATA_i[7];
    assign st_busy       = PRDATA_i[6];
    assign st_al         = PRDATA_i[5];
    assign st_tip        = PRDATA_i[1];
    assign unused_prdata = ^PRDATA_i[31:8];

    function automatic logic [7:0] tx_byte(logic [1:0] stp, logic wr, logic [6:0] d,
                                           logic [7:0] r, logic [7:0] w);
        case (stp)
            2'd0:    return {d, 1'b0};
            2'd1:    return r;
            2'd2:    return wr ? w : {d, 1'b1};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] cmd_byte(logic [1:0] stp, logic wr);
        case (stp)
            2'd0:    return 8'h91;
            2'd1:    return 8'h11;
            2'd2:    return wr ? 8'h51 : 8'h91;
            default: return 8'h69;
        endcase
    endfunction

    function automatic apb_t access_for(state_t st, logic [1:0] stp, logic wr, logic [6:0] d,
                                        logic [7:0] r, logic [7:0] w);
        apb_t a;
        a = '0;
        case (st)
            RST_PRE:   begin a.addr = A_PRE;  a.wdata = {16'h0, PRESCALE}; a.write = 1'b1; end
            RST_CTRL:  begin a.addr = A_CTRL; a.wdata = 32'h80;            a.write = 1'b1; end
            WR_TX: begin
                a.addr = A_TX; a.wdata = {24'h0, tx_byte(stp, wr, d, r, w)}; a.write = 1'b1;
            end
            WR_CMD:    begin a.addr = A_CMD; a.wdata = {24'h0, cmd_byte(stp, wr)}; a.write = 1'b1; end
            STOP_CMD:  begin a.addr = A_CMD; a.wdata = 32'h41; a.write = 1'b1; end
            POLL, STOP_POLL: a.addr = A_STATUS;
            RD_RX:     a.addr = A_RX;
            default:   a = '0;
        endcase
        return a;
    endfunction

    // Each completing access launches the next setup on the same edge, so there is no
    // idle cycle between accesses; STATUS is evaluated on the poll's completing edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= RST_PRE;
            step      <= 2'd0;
            req_wr    <= 1'b0;
            req_dev   <= '0;
            req_reg   <= '0;
            req_dat   <= '0;
            apb       <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (psel && !penable) begin
                penable <= 1'b1;
            end else if (psel && PREADY_i) begin
                penable <= 1'b0;
                case (state)
                    RST_PRE: begin
                        state <= RST_CTRL;
                        apb   <= access_for(RST_CTRL, step, req_wr, req_dev, req_reg, req_dat);
                    end
                    RST_CTRL: begin
                        state     <= IDLE;
                        psel      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                    WR_TX: begin
                        state <= WR_CMD;
                        apb   <= access_for(WR_CMD, step, req_wr, req_dev, req_reg, req_dat);
                    end
                    WR_CMD: begin
                        state <= POLL;
                        apb   <= access_for(POLL, step, req_wr, req_dev, req_reg, req_dat);
                    end
                    POLL: begin
                        if (!st_tip) begin
                            if (st_al) begin
                                state <= RESP; psel <= 1'b0; rsp_valid <= 1'b1;
                                rsp_err <= 2'b10; rsp_rdata <= 8'h00;
                            end else if (step == 2'd3) begin
                                state <= RD_RX;
                                apb   <= access_for(RD_RX, step, req_wr, req_dev, req_reg, req_dat);
                            end else if (st_rxack) begin
                                state <= STOP_CMD;
                                apb   <= access_for(STOP_CMD, step, req_wr, req_dev, req_reg,
                                                    req_dat);
                            end else if (req_wr && step == 2'd2) begin
                                state <= RESP; psel <= 1'b0; rsp_valid <= 1'b1;
                                rsp_err <= 2'b00; rsp_rdata <= 8'h00;
                            end else begin
                                step  <= step + 2'd1;
                                state <= (step == 2'd2) ? WR_CMD : WR_TX;
                                apb   <= access_for((step == 2'd2) ? WR_CMD : WR_TX, step + 2'd1,
                                                    req_wr, req_dev, req_reg, req_dat);
                            end
                        end
                    end
                    STOP_CMD: begin
                        state <= STOP_POLL;
                        apb   <= access_for(STOP_POLL, step, req_wr, req_dev, req_reg, req_dat);
                    end
                    STOP_POLL: begin
                        if (!st_busy) begin
                            state <= RESP; psel <= 1'b0; rsp_valid <= 1'b1;
                            rsp_err <= 2'b01; rsp_rdata <= 8'h00;
                        end
                    end
                    RD_RX: begin
                        state <= RESP; psel <= 1'b0; rsp_valid <= 1'b1;
                        rsp_err <= 2'b00; rsp_rdata <= PRDATA_i[7:0];
                    end
                    default: psel <= 1'b0;
                endcase
            end else if (!psel) begin
                case (state)
                    RST_PRE: begin
                        psel <= 1'b1;
                        apb  <= access_for(RST_PRE, step, req_wr, req_dev, req_reg, req_dat);
                    end
                    IDLE: begin
                        if (req_valid_i && req_ready) begin
                            req_wr    <= req_write_i;
                            req_dev   <= req_dev_i;
                            req_reg   <= req_reg_i;
                            req_dat   <= req_wdata_i;
                            req_ready <= 1'b0;
                            step      <= 2'd0;
                            state     <= WR_TX;
                            psel      <= 1'b1;
                            apb       <= access_for(WR_TX, 2'd0, req_write_i, req_dev_i,
                                                    req_reg_i, req_wdata_i);
                        end
                    end
                    RESP: begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_ready_o = req_ready;
    assign rsp_valid_o = rsp_valid;
    assign rsp_rdata_o = rsp_rdata;
    assign rsp_err_o   = rsp_err;
    assign PADDR_o     = apb.addr;
    assign PWDATA_o    = apb.wdata;
    assign PWRITE_o    = apb.write;
    assign PSEL_o      = psel;
    assign PENABLE_o   = penable;

endmodule
